// File: rtl/video_timing_checker.sv
// Measures H/V timing of an incoming video stream, locks after consecutive good
// frames, and checks a frame-numbered test pattern while locked.
module video_timing_checker #(
  parameter bit          C_HD_POL      = 1'b1,
  parameter bit          C_VD_POL      = 1'b1,
  parameter logic [15:0] C_H_TOTAL     = 16'd858,
  parameter logic [15:0] C_H_SIZE      = 16'd720,
  parameter logic [15:0] C_V_TOTAL     = 16'd525,
  parameter logic [15:0] C_V_SIZE      = 16'd480,
  parameter logic [3:0]  C_LOCK_FRAMES = 4'd2
) (
  input  logic        CK,
  input  logic        RST,
  input  logic        CKE_i,
  input  logic        DEN_i,
  input  logic        HD_i,
  input  logic        VD_i,
  input  logic [7:0]  R_i,
  input  logic [7:0]  G_i,
  input  logic [7:0]  B_i,
  output logic [15:0] H_TOTAL_o,
  output logic [15:0] H_ACT_o,
  output logic [15:0] HSYNC_W_o,
  output logic [15:0] V_TOTAL_o,
  output logic [15:0] V_ACT_o,
  output logic [15:0] VSYNC_W_o,
  output logic        LOCK_o,
  output logic        PIX_ERR_o,
  output logic [15:0] ERR_CNT_o,
  output logic [7:0]  F_CTR_o
);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCK} state_t;

  state_t      r_state, w_state_nxt;
  logic [3:0]  r_good, w_good_nxt;
  logic        w_fvalid_clr;

  logic        r_hd_d, r_vd_d;
  logic [15:0] r_hcnt, r_hden, r_hsw, r_vcnt, r_vact, r_vsw, r_x;
  logic [15:0] r_htot, r_hact, r_hsw_o, r_vtot_o, r_vact_o, r_vsw_o, r_errcnt;
  logic        r_line_den, r_bad, r_fvalid, r_pixerr;
  logic [7:0]  r_fctr;

  logic        w_hd_act, w_vd_act, w_hd_le, w_hd_te, w_vd_le, w_vd_te;
  logic        w_line_bad, w_frame_good;
  logic [15:0] w_vtot, w_vact_end, w_x, w_y;
  logic [4:0]  w_good_inc;
  logic        w_check, w_first, w_err_first, w_err_other, w_err;

  assign w_hd_act = (HD_i == C_HD_POL);
  assign w_vd_act = (VD_i == C_VD_POL);
  assign w_hd_le  = CKE_i &  w_hd_act & ~r_hd_d;
  assign w_hd_te  = CKE_i & ~w_hd_act &  r_hd_d;
  assign w_vd_le  = CKE_i &  w_vd_act & ~r_vd_d;
  assign w_vd_te  = CKE_i & ~w_vd_act &  r_vd_d;

  // The HD edge that coincides with VD closes the last line of the ending frame.
  assign w_line_bad   = (r_hcnt != C_H_TOTAL) || ((r_hden != '0) && (r_hden != C_H_SIZE));
  assign w_vtot       = r_vcnt + {15'd0, w_hd_le};
  assign w_vact_end   = r_vact + {15'd0, w_hd_le & r_line_den};
  assign w_frame_good = !(r_bad || (w_hd_le && w_line_bad)) &&
                        (w_vtot == C_V_TOTAL) && (w_vact_end == C_V_SIZE);

  assign w_x         = w_hd_le ? '0 : r_x;
  assign w_y         = w_vd_le ? '0 : w_vact_end;
  assign w_check     = CKE_i & DEN_i & (r_state == S_LOCK);
  assign w_first     = (w_x == '0) && (w_y == '0);
  assign w_err_first = (G_i != R_i) || (B_i != (8'd0 - R_i)) ||
                       (r_fvalid && (R_i != (r_fctr + 8'd1)));
  assign w_err_other = (R_i != (w_x[7:0] + r_fctr)) || (G_i != (w_y[7:0] + r_fctr)) ||
                       (B_i != (w_x[7:0] + w_y[7:0] - r_fctr));
  assign w_err       = w_check & (w_first ? w_err_first : w_err_other);
  assign w_good_inc  = {1'b0, r_good} + 5'd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_good_nxt   = r_good;
    w_fvalid_clr = 1'b0;
    if (w_vd_le) begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQ;
          w_good_nxt  = '0;
        end
        S_ACQ: begin
          if (w_frame_good) begin
            w_good_nxt = w_good_inc[3:0];
            if (w_good_inc >= {1'b0, C_LOCK_FRAMES}) w_state_nxt = S_LOCK;
          end else begin
            w_good_nxt = '0;
          end
        end
        S_LOCK: begin
          if (!w_frame_good) begin
            w_state_nxt  = S_ACQ;
            w_good_nxt   = '0;
            w_fvalid_clr = 1'b1;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_good  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_good  <= w_good_nxt;
    end
  end

  always_ff @(posedge CK) begin
    if (RST) begin
      // Syncs treated as already active so a sync held through reset is not an edge.
      r_hd_d     <= 1'b1;
      r_vd_d     <= 1'b1;
      r_hcnt     <= '0;  r_hden   <= '0;  r_hsw    <= '0;
      r_vcnt     <= '0;  r_vact   <= '0;  r_vsw    <= '0;  r_x <= '0;
      r_htot     <= '0;  r_hact   <= '0;  r_hsw_o  <= '0;
      r_vtot_o   <= '0;  r_vact_o <= '0;  r_vsw_o  <= '0;
      r_errcnt   <= '0;  r_fctr   <= '0;
      r_line_den <= 1'b0; r_bad   <= 1'b0; r_fvalid <= 1'b0; r_pixerr <= 1'b0;
    end else if (CKE_i) begin
      r_hd_d <= w_hd_act;
      r_vd_d <= w_vd_act;

      if (w_hd_le) begin
        r_htot     <= r_hcnt;
        r_hact     <= r_hden;
        r_hcnt     <= 16'd1;
        r_hden     <= {15'd0, DEN_i};
        r_line_den <= DEN_i;
      end else begin
        if (r_hcnt != '1) r_hcnt <= r_hcnt + 16'd1;
        if (DEN_i && (r_hden != '1)) r_hden <= r_hden + 16'd1;
        r_line_den <= r_line_den | DEN_i;
      end

      if (w_hd_le)                        r_hsw <= 16'd1;
      else if (w_hd_act && r_hsw != '1)   r_hsw <= r_hsw + 16'd1;
      if (w_hd_te)                        r_hsw_o <= r_hsw;

      if (w_vd_le) begin
        r_vtot_o <= w_vtot;
        r_vact_o <= w_vact_end;
        r_vcnt   <= '0;
        r_vact   <= '0;
        r_bad    <= 1'b0;
        r_vsw    <= {15'd0, w_hd_le};
      end else begin
        r_vcnt <= w_vtot;
        r_vact <= w_vact_end;
        if (w_hd_le && w_line_bad) r_bad <= 1'b1;
        if (w_vd_act && w_hd_le)   r_vsw <= r_vsw + 16'd1;
      end
      if (w_vd_te) r_vsw_o <= r_vsw;

      r_x <= w_x + {15'd0, DEN_i};

      if (w_check && w_first) r_fctr <= R_i;
      if (w_fvalid_clr)               r_fvalid <= 1'b0;
      else if (w_check && w_first)    r_fvalid <= 1'b1;

      if (w_err) begin
        if (r_errcnt != '1) r_errcnt <= r_errcnt + 16'd1;
        r_pixerr <= 1'b1;
      end
    end
  end

  assign H_TOTAL_o = r_htot;
  assign H_ACT_o   = r_hact;
  assign HSYNC_W_o = r_hsw_o;
  assign V_TOTAL_o = r_vtot_o;
  assign V_ACT_o   = r_vact_o;
  assign VSYNC_W_o = r_vsw_o;
  assign LOCK_o    = (r_state == S_LOCK);
  assign PIX_ERR_o = r_pixerr;
  assign ERR_CNT_o = r_errcnt;
  assign F_CTR_o   = r_fctr;

endmodule

// File: doc/video_timing_checker.md
VIDEO_TIMING_CHECKER -- requirements
Module: video_timing_checker

Interface
REQ-001 SHALL have parameter C_HD_POL, default 1, HD_i level during sync.
REQ-002 SHALL have parameter C_VD_POL, default 1, VD_i level during sync.
REQ-003 SHALL have parameter C_H_TOTAL [15:0], default 858, expected clocks per line.
REQ-004 SHALL have parameter C_H_SIZE [15:0], default 720, expected active pixels per line.
REQ-005 SHALL have parameter C_V_TOTAL [15:0], default 525, expected lines per frame.
REQ-006 SHALL have parameter C_V_SIZE [15:0], default 480, expected active lines per frame.
REQ-007 SHALL have parameter C_LOCK_FRAMES [3:0], default 2, consecutive good frames needed to lock.
REQ-008 SHALL have port CK, input, 1, the one clock; all logic rises on CK.
REQ-009 SHALL have port RST, input, 1, reset, synchronous and active-high.
REQ-010 SHALL have port CKE_i, input, 1, clock enable; low freezes all state and ignores inputs.
REQ-011 SHALL have port DEN_i, input, 1, data enable.
REQ-012 SHALL have ports HD_i and VD_i, input, 1 each, H and V sync.
REQ-013 SHALL have ports R_i, G_i and B_i, input, 8 each, pixel data.
REQ-014 SHALL have ports H_TOTAL_o and H_ACT_o, output, 16 each, last line period and last line DEN count.
REQ-015 SHALL have port HSYNC_W_o, output, 16, last HD active width in clocks.
REQ-016 SHALL have ports V_TOTAL_o, V_ACT_o and VSYNC_W_o, output, 16 each, lines per frame, DEN lines, VD width in lines.
REQ-017 SHALL have port LOCK_o, output, 1, high in LOCK state.
REQ-018 SHALL have port PIX_ERR_o, output, 1, sticky error flag.
REQ-019 SHALL have port ERR_CNT_o, output, 16, saturating error count.
REQ-020 SHALL have port F_CTR_o, output, 8, recovered frame number.

Function
REQ-021 Cycle SHALL mean a CK edge with CKE_i=1; leading edge SHALL mean previous sample inactive and current sample equal to the POL level; trailing edge SHALL be the reverse.
REQ-022 H counter SHALL reload to 1 on HD leading edge, else increment, saturating at FFFF; on the leading edge, H_TOTAL_o SHALL load the pre-reload count and H_ACT_o the DEN count of the ending line.
REQ-023 HSYNC_W_o SHALL load the HD-active cycle count on HD trailing edge.
REQ-024 V_TOTAL_o SHALL count HD leading edges, the one coincident with VD included, latched on VD leading edge.
REQ-025 V_ACT_o SHALL count lines with at least one DEN cycle, latched on VD leading edge.
REQ-026 VSYNC_W_o SHALL count HD leading edges while VD is active, latched on VD trailing edge.
REQ-027 All outputs SHALL register on the sampling edge, visible one CK later.
REQ-028 A line SHALL be bad if H_TOTAL is not C_H_TOTAL, or if H_ACT is neither 0 nor C_H_SIZE.
REQ-029 A frame SHALL be good if no bad line occurred, V_TOTAL equals C_V_TOTAL and V_ACT equals C_V_SIZE.
REQ-030 FSM SHALL have states IDLE, ACQ and LOCK; IDLE SHALL go to ACQ on the first VD leading edge without evaluating the partial frame.
REQ-031 In ACQ, each VD leading edge SHALL increment the good count on a good frame and clear it on a bad one; reaching C_LOCK_FRAMES SHALL enter LOCK.
REQ-032 In LOCK, a bad frame SHALL return to ACQ with good count 0 and the f-valid flag cleared.
REQ-033 Pixel checks SHALL run only in LOCK; x SHALL be the DEN index within a line and y the DEN-line index within a frame, both 16-bit and cleared by HD and VD leading edges respectively.
REQ-034 First DEN pixel of a frame (x=0,y=0): F_CTR SHALL load R_i; an error SHALL count if G_i differs from R_i, if B_i differs from (-R_i) mod 256, or if f-valid is set and R_i is not (F_CTR+1) mod 256; f-valid SHALL then set.
REQ-035 Other DEN pixels SHALL expect R=(x+f), G=(y+f) and B=(x+y-f), each mod 256; any mismatching component SHALL add one error per pixel.
REQ-036 ERR_CNT_o SHALL increment one CK after the bad sample and saturate at FFFF; PIX_ERR_o SHALL set with it and clear only on RST.
REQ-037 Frame number wrap from 255 to 0 SHALL NOT be an error.

Reset
REQ-038 When RST=1 on a CK edge, regardless of CKE_i, all outputs and counters SHALL clear to 0, FSM SHALL go to IDLE and f-valid SHALL clear; reset mid-frame SHALL require a fresh VD leading edge before measurement resumes.

Verification
REQ-039 Nominal 858x525 stream (HD 62, VD 6 lines, pattern per REQ-035): measured outputs SHALL read 858/720/62/525/480/6; LOCK_o SHALL rise at the 3rd VD leading edge; ERR_CNT_o SHALL stay 0.
REQ-040 Locked, invert G_i bit0 on one pixel: ERR_CNT_o SHALL go 0->1 and PIX_ERR_o SHALL be 1 one CK later.
REQ-041 Locked, one line stretched to 859: at the next VD edge LOCK_o SHALL go 0, and it SHALL go 1 again after 2 good frames.
REQ-042 Frame number sequence 254, 255, 0, 1: no error SHALL be counted; skipping 0 to 2 SHALL count exactly 1 error.
REQ-043 CKE_i alternating 1/0 on the nominal stream: results SHALL be identical to REQ-039.
REQ-044 RST pulse mid-frame while locked: all outputs SHALL be 0 next CK, and relock SHALL occur at the 3rd VD edge after reset.
